xgmii_rx_adapter: RTL and testbench
===================================

// Module: xgmii_rx_adapter
// PURPOSE
//  10G receive front end. Sits between the 64b/66b decoder (XGMII 64-bit data + 8-bit ctrl) and the MAC rx
//  input of the eth_rx stack. Turns XGMII control characters into mac_valid/start/term/len/cancel framing.
//  Detects malformed or errored frames and flags them with a cancel pulse. Keeps saturating frame/error counters.
// PARAMETERS
//  MAX_BEATS  190  max 64-bit beats per frame (start..term inclusive); exceeding it cancels the frame
//  CNT_W      16   width of the statistics counters
// PORTS
//  clk            in   1   single clock
//  reset          in   1   synchronous, active-high reset
//  xgmii_valid_i  in   1   decoder beat valid (0 = gearbox slip cycle, beat ignored)
//  xgmii_rxd_i    in   64  XGMII data, lane k = bits [8k+7:8k], lane 0 first on wire
//  xgmii_rxc_i    in   8   XGMII ctrl, bit k = 1 -> lane k is a control character
//  mac_valid_o    out  1   beat valid towards mac_rx
//  mac_data_o     out  64  beat data, byte lanes as received
//  mac_start_o    out  2   [0] start char in lane 0, [1] start char in lane 4
//  mac_term_o     out  1   last beat of frame
//  mac_len_o      out  4   valid data bytes in beat: 8 on non-term beats, 0..7 on term beat
//  phy_cancel_o   out  1   one-cycle pulse: current frame aborted, downstream discards it
//  frame_cnt_o    out  CNT_W  frames terminated cleanly, saturating
//  err_cnt_o      out  CNT_W  frames cancelled, saturating
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, beat counter 0. Reset mid-frame drops the frame with no cancel.
//  - Latency: all outputs registered, 1 cycle after the input beat. No backpressure.
//  - xgmii_valid_i=0: state and counters hold; mac_valid_o=0, phy_cancel_o=0 in the next cycle.
//  - Constants: S=8'hFB, T=8'hFD, E=8'hFE, I=8'h07.
//  - IDLE:
//      rxc=8'h01 & lane0=S -> mac_valid=1, mac_start=2'b01, len=8, beat_cnt=1, go FRAME
//      rxc[7:4]=4'h1 & lane4=S & lanes0-3 are all control, none E -> mac_valid=1, mac_start=2'b10, len=8, go FRAME
//      all other beats -> no output, including stray T or E (no cancel, since no frame is open).
//  - FRAME:
//      rxc=0 -> data beat, mac_valid=1, len=8, beat_cnt++.
//      Term pattern: lowest set rxc bit k has lane k = T, and all lanes >k are control, none E.
//        -> mac_valid=1, mac_term=1, mac_len=k (k=0 is a valid empty term beat), frame_cnt++, go IDLE.
//      Any other beat with rxc!=0 (E anywhere, S, control without T, E after T) -> phy_cancel=1,
//        mac_valid=0, err_cnt++, go IDLE.
//      S in the same beat as a cancel is not re-armed; the next frame needs a fresh S in IDLE.
//      beat_cnt reaching MAX_BEATS without term -> cancel on the offending beat, err_cnt++, go IDLE.
//  - mac_start_o and mac_term_o are never both set. phy_cancel_o and mac_valid_o are never both set.
//  - mac_data_o is passed as received, including S/T/control lanes. mac_len and the start lane define validity.
//  - Counters saturate at all-ones; they do not wrap. Cleared only by reset.
// STRUCTURE
//  - Shared package xgmii_pkg: XGMII_S/T/E/I constants, lane count 8, state enum {IDLE, FRAME}.
//  - Sub-module xgmii_term_decode (combinational): from rxd/rxc, output is_term, term_lane[2:0], has_err,
//    start_l0, start_l4. The top level holds the FSM, beat counter, output registers and counters.
// TESTING
//  - Frame with S in lane0, 3 data beats, then T in lane 5 -> start=01 beat, 3 beats len=8,
//    a term beat with len=5, frame_cnt=1.
//  - I in lanes 0-3 and S in lane4, 2 data beats, then T in lane 0 -> start=10, term beat len=0,
//    no cancel, frame_cnt=1.
//  - E (rxc=8'h08, lane3=FE) on beat 2 of a frame -> phy_cancel one cycle, no term, err_cnt=1.
//    The next clean frame is received normally.
//  - xgmii_valid_i=0 inserted between data beats -> output gap, frame intact, len/term unaffected.
//  - MAX_BEATS=4 and a 6-beat frame -> cancel on beat 4, remaining beats ignored until a fresh S.
//  - Reset mid-frame, then T arrives -> no output, counters 0.
//    frame_cnt forced near saturation (CNT_W=2) -> saturates at 3.

Source files
------------

// File: rtl/xgmii_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : xgmii_pkg
//  Brief   : XGMII control characters, lane geometry and rx FSM state codes.
//  Rev     : 1.0  initial release
// ============================================================================
package xgmii_pkg;

   localparam logic [7:0] XGMII_S     = 8'hFB;
   localparam logic [7:0] XGMII_T     = 8'hFD;
   localparam logic [7:0] XGMII_E     = 8'hFE;
   localparam logic [7:0] XGMII_I     = 8'h07;
   localparam int         XGMII_LANES = 8;

   typedef logic [0:0] xgmii_state_t;
   localparam xgmii_state_t ST_IDLE  = 1'b0;
   localparam xgmii_state_t ST_FRAME = 1'b1;

endpackage : xgmii_pkg
`default_nettype wire

// File: rtl/xgmii_term_decode.sv
`default_nettype none
// ============================================================================
//  Module  : xgmii_term_decode
//  Brief   : Combinational classification of one XGMII beat (start/term/error).
//  Rev     : 1.0  initial release
// ============================================================================
module xgmii_term_decode
   import xgmii_pkg::*;
(
   input  logic [63:0] i_rxd,
   input  logic [7:0]  i_rxc,
   output logic        o_is_term,
   output logic [2:0]  o_term_lane,
   output logic        o_has_err,
   output logic        o_start_l0,
   output logic        o_start_l4
);

   logic [XGMII_LANES-1:0] w_is_e;
   logic [2:0]             w_lo;
   logic [7:0]             w_lo_byte;
   logic                   w_shape;

   for (genvar k = 0; k < XGMII_LANES; k++) begin : g_lane
      assign w_is_e[k] = i_rxc[k] && (i_rxd[8*k +: 8] == XGMII_E);
   end

   always_comb begin
      w_lo = 3'd0;
      for (int k = XGMII_LANES - 1; k >= 0; k--) begin
         if (i_rxc[k]) w_lo = 3'(k);
      end
   end

   assign w_lo_byte = i_rxd[{w_lo, 3'b000} +: 8];
   // Lowest control lane k and every lane above it must be control.
   assign w_shape   = (i_rxc == (8'hFF << w_lo));

   assign o_has_err   = |w_is_e;
   assign o_term_lane = w_lo;
   assign o_is_term   = (i_rxc != 8'h00) && w_shape && (w_lo_byte == XGMII_T) && !o_has_err;
   assign o_start_l0  = (i_rxc == 8'h01) && (i_rxd[7:0] == XGMII_S);
   assign o_start_l4  = (i_rxc == 8'h1F) && (i_rxd[39:32] == XGMII_S) && !o_has_err;

endmodule : xgmii_term_decode
`default_nettype wire

// File: rtl/xgmii_rx_adapter.sv
`default_nettype none
// ============================================================================
//  Module  : xgmii_rx_adapter
//  Brief   : XGMII 64b rx to MAC framing with cancel and saturating stats.
//  Rev     : 1.0  initial release
// ============================================================================
module xgmii_rx_adapter
   import xgmii_pkg::*;
#(
   parameter int MAX_BEATS = 190,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             xgmii_valid_i,
   input  logic [63:0]      xgmii_rxd_i,
   input  logic [7:0]       xgmii_rxc_i,
   output logic             mac_valid_o,
   output logic [63:0]      mac_data_o,
   output logic [1:0]       mac_start_o,
   output logic             mac_term_o,
   output logic [3:0]       mac_len_o,
   output logic             phy_cancel_o,
   output logic [CNT_W-1:0] frame_cnt_o,
   output logic [CNT_W-1:0] err_cnt_o
);

   localparam int BC_W = $clog2(MAX_BEATS + 1);

   logic             w_is_term;
   logic [2:0]       w_term_lane;
   logic             w_has_err;
   logic             w_start_l0;
   logic             w_start_l4;
   logic [BC_W-1:0]  w_next_cnt;

   xgmii_state_t     r_state;
   logic [BC_W-1:0]  r_beat_cnt;
   logic             r_valid;
   logic [63:0]      r_data;
   logic [1:0]       r_start;
   logic             r_term;
   logic [3:0]       r_len;
   logic             r_cancel;
   logic [CNT_W-1:0] r_frame_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   xgmii_term_decode u_decode (
      .i_rxd       (xgmii_rxd_i),
      .i_rxc       (xgmii_rxc_i),
      .o_is_term   (w_is_term),
      .o_term_lane (w_term_lane),
      .o_has_err   (w_has_err),
      .o_start_l0  (w_start_l0),
      .o_start_l4  (w_start_l4)
   );

   assign w_next_cnt = r_beat_cnt + 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_beat_cnt  <= '0;
         r_valid     <= 1'b0;
         r_data      <= '0;
         r_start     <= 2'b00;
         r_term      <= 1'b0;
         r_len       <= 4'd0;
         r_cancel    <= 1'b0;
         r_frame_cnt <= '0;
         r_err_cnt   <= '0;
      end else begin
         r_valid  <= 1'b0;
         r_start  <= 2'b00;
         r_term   <= 1'b0;
         r_len    <= 4'd0;
         r_cancel <= 1'b0;
         if (xgmii_valid_i) begin
            r_data <= xgmii_rxd_i;
            case (r_state)
               ST_IDLE: begin
                  if (w_start_l0 || w_start_l4) begin
                     r_valid    <= 1'b1;
                     r_start    <= {w_start_l4, w_start_l0};
                     r_len      <= 4'd8;
                     r_beat_cnt <= {{(BC_W-1){1'b0}}, 1'b1};
                     r_state    <= ST_FRAME;
                  end
               end
               default: begin
                  // A data beat that would reach the limit leaves no room for a term.
                  if (xgmii_rxc_i == 8'h00 && w_next_cnt < BC_W'(MAX_BEATS)) begin
                     r_valid    <= 1'b1;
                     r_len      <= 4'd8;
                     r_beat_cnt <= w_next_cnt;
                  end else if (w_is_term) begin
                     r_valid    <= 1'b1;
                     r_term     <= 1'b1;
                     r_len      <= {1'b0, w_term_lane};
                     r_beat_cnt <= '0;
                     r_state    <= ST_IDLE;
                     if (r_frame_cnt != {CNT_W{1'b1}}) r_frame_cnt <= r_frame_cnt + 1'b1;
                  end else begin
                     r_cancel   <= 1'b1;
                     r_beat_cnt <= '0;
                     r_state    <= ST_IDLE;
                     if (r_err_cnt != {CNT_W{1'b1}}) r_err_cnt <= r_err_cnt + 1'b1;
                  end
               end
            endcase
         end
      end
   end

   assign mac_valid_o  = r_valid;
   assign mac_data_o   = r_data;
   assign mac_start_o  = r_start;
   assign mac_term_o   = r_term;
   assign mac_len_o    = r_len;
   assign phy_cancel_o = r_cancel;
   assign frame_cnt_o  = r_frame_cnt;
   assign err_cnt_o    = r_err_cnt;

endmodule : xgmii_rx_adapter
`default_nettype wire

// File: tb/tb_xgmii_rx_adapter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_xgmii_rx_adapter
//  Brief   : Scoreboard bench; instance A default sizing, instance B short limits.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_xgmii_rx_adapter;

   typedef struct packed {
      logic        cancel;
      logic [1:0]  start;
      logic        term;
      logic [3:0]  len;
      logic [63:0] data;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        a_v = 1'b0, b_v = 1'b0;
   logic [63:0] a_d = '0, b_d = '0;
   logic [7:0]  a_c = '0, b_c = '0;

   logic        a_valid, a_term, a_cancel, b_valid, b_term, b_cancel;
   logic [63:0] a_data, b_data;
   logic [1:0]  a_start, b_start;
   logic [3:0]  a_len, b_len;
   logic [15:0] a_fcnt, a_ecnt;
   logic [1:0]  b_fcnt, b_ecnt;

   exp_t qa[$];
   exp_t qb[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   xgmii_rx_adapter dut_a (
      .clk(clk), .reset(reset), .xgmii_valid_i(a_v), .xgmii_rxd_i(a_d), .xgmii_rxc_i(a_c),
      .mac_valid_o(a_valid), .mac_data_o(a_data), .mac_start_o(a_start), .mac_term_o(a_term),
      .mac_len_o(a_len), .phy_cancel_o(a_cancel), .frame_cnt_o(a_fcnt), .err_cnt_o(a_ecnt)
   );

   xgmii_rx_adapter #(.MAX_BEATS(4), .CNT_W(2)) dut_b (
      .clk(clk), .reset(reset), .xgmii_valid_i(b_v), .xgmii_rxd_i(b_d), .xgmii_rxc_i(b_c),
      .mac_valid_o(b_valid), .mac_data_o(b_data), .mac_start_o(b_start), .mac_term_o(b_term),
      .mac_len_o(b_len), .phy_cancel_o(b_cancel), .frame_cnt_o(b_fcnt), .err_cnt_o(b_ecnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cmp_beat(input string tag, input exp_t e, input logic v, input logic cn,
                           input logic [1:0] st, input logic tm, input logic [3:0] ln,
                           input logic [63:0] dt);
      logic bad;
      checks++;
      if (e.cancel) bad = (cn !== 1'b1) || (v !== 1'b0);
      else          bad = (v !== 1'b1) || (cn !== 1'b0) || (st !== e.start) ||
                          (tm !== e.term) || (ln !== e.len) || (dt !== e.data);
      if (bad) begin
         errors++;
         $display("FAIL %s beat: got v=%0b cancel=%0b start=%b term=%0b len=%0d data=%h expected cancel=%0b start=%b term=%0b len=%0d data=%h",
                  tag, v, cn, st, tm, ln, dt, e.cancel, e.start, e.term, e.len, e.data);
      end
   endtask

   // Monitors: every presented beat or cancel must match the head of its queue.
   always @(negedge clk) begin
      if (a_valid === 1'b1 || a_cancel === 1'b1) begin
         if (qa.size() == 0) begin
            checks++; errors++;
            $display("FAIL A unexpected: got valid=%0b cancel=%0b expected no output", a_valid, a_cancel);
         end else cmp_beat("A", qa.pop_front(), a_valid, a_cancel, a_start, a_term, a_len, a_data);
      end
   end

   always @(negedge clk) begin
      if (b_valid === 1'b1 || b_cancel === 1'b1) begin
         if (qb.size() == 0) begin
            checks++; errors++;
            $display("FAIL B unexpected: got valid=%0b cancel=%0b expected no output", b_valid, b_cancel);
         end else cmp_beat("B", qb.pop_front(), b_valid, b_cancel, b_start, b_term, b_len, b_data);
      end
   end

   task automatic exp_beat(input bit b, input logic [1:0] st, input logic tm, input logic [3:0] ln,
                           input logic [63:0] d);
      exp_t e;
      e.cancel = 1'b0; e.start = st; e.term = tm; e.len = ln; e.data = d;
      if (b) qb.push_back(e); else qa.push_back(e);
   endtask

   task automatic exp_cancel(input bit b);
      exp_t e;
      e = '0;
      e.cancel = 1'b1;
      if (b) qb.push_back(e); else qa.push_back(e);
   endtask

   task automatic send(input bit b, input logic v, input logic [63:0] d, input logic [7:0] c);
      if (b) begin b_v = v; b_d = d; b_c = c; a_v = 1'b0; end
      else   begin a_v = v; a_d = d; a_c = c; b_v = 1'b0; end
      @(posedge clk); #1;
   endtask

   localparam logic [63:0] IDLE_D = 64'h0707070707070707;
   localparam logic [63:0] S0     = 64'hD5555555555555FB;
   localparam logic [63:0] S4     = 64'hD55555FB07070707;
   localparam logic [63:0] T5     = 64'h0707FD4444444444;
   localparam logic [63:0] T0     = 64'h07070707070707FD;
   localparam logic [63:0] T7     = 64'hFD88888888888888;
   localparam logic [63:0] T3     = 64'h07070707FD999999;
   localparam logic [63:0] T4     = 64'h070707FDBBBBBBBB;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("reset a_valid", {63'd0, a_valid}, 64'd0);
      chk("reset a_cancel", {63'd0, a_cancel}, 64'd0);
      chk("reset a_start_term", {61'd0, a_start, a_term}, 64'd0);
      chk("reset a_fcnt", {48'd0, a_fcnt}, 64'd0);
      chk("reset a_ecnt", {48'd0, a_ecnt}, 64'd0);
      reset = 1'b0;
      send(0, 1, IDLE_D, 8'hFF);

      // Lane0 start, three data beats, term in lane 5.
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h11}});         send(0, 1, {8{8'h11}}, 8'h00);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h22}});         send(0, 1, {8{8'h22}}, 8'h00);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h33}});         send(0, 1, {8{8'h33}}, 8'h00);
      exp_beat(0, 2'b00, 1, 4'd5, T5);                 send(0, 1, T5, 8'hE0);
      chk("t1 frame_cnt", {48'd0, a_fcnt}, 64'd1);
      send(0, 1, IDLE_D, 8'hFF);

      // Lane4 start, two data beats, empty term beat in lane 0.
      exp_beat(0, 2'b10, 0, 4'd8, S4);                 send(0, 1, S4, 8'h1F);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h5A}});         send(0, 1, {8{8'h5A}}, 8'h00);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'hA5}});         send(0, 1, {8{8'hA5}}, 8'h00);
      exp_beat(0, 2'b00, 1, 4'd0, T0);                 send(0, 1, T0, 8'hFF);
      chk("t2 frame_cnt", {48'd0, a_fcnt}, 64'd2);
      chk("t2 err_cnt", {48'd0, a_ecnt}, 64'd0);

      // Stray T and E while idle produce nothing.
      send(0, 1, 64'h55555555555555FD, 8'h01);
      send(0, 1, {8{8'hFE}}, 8'hFF);
      chk("stray err_cnt", {48'd0, a_ecnt}, 64'd0);

      // Error on beat 2, trailing beats ignored, then a clean frame with term in lane 7.
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_cancel(0);                                   send(0, 1, 64'h66666666FE666666, 8'h08);
      send(0, 1, {8{8'h77}}, 8'h00);
      send(0, 1, T0, 8'hFF);
      chk("e err_cnt", {48'd0, a_ecnt}, 64'd1);
      chk("e frame_cnt", {48'd0, a_fcnt}, 64'd2);
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h12}});         send(0, 1, {8{8'h12}}, 8'h00);
      exp_beat(0, 2'b00, 1, 4'd7, T7);                 send(0, 1, T7, 8'h80);
      chk("post-e frame_cnt", {48'd0, a_fcnt}, 64'd3);

      // Slip cycle between data beats; term lands in lane 3.
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'hAB}});         send(0, 1, {8{8'hAB}}, 8'h00);
      send(0, 0, {8{8'hFE}}, 8'hFF);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'hCD}});         send(0, 1, {8{8'hCD}}, 8'h00);
      exp_beat(0, 2'b00, 1, 4'd3, T3);                 send(0, 1, T3, 8'hF8);
      chk("gap frame_cnt", {48'd0, a_fcnt}, 64'd4);

      // E after T inside the same beat cancels.
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_cancel(0);                                   send(0, 1, 64'h0707FE0707FDAAAA, 8'hFC);
      chk("e-after-t err_cnt", {48'd0, a_ecnt}, 64'd2);
      chk("e-after-t frame_cnt", {48'd0, a_fcnt}, 64'd4);

      // Reset mid-frame: the following term is ignored and counters clear.
      exp_beat(0, 2'b01, 0, 4'd8, S0);                 send(0, 1, S0, 8'h01);
      exp_beat(0, 2'b00, 0, 4'd8, {8{8'h3C}});         send(0, 1, {8{8'h3C}}, 8'h00);
      reset = 1'b1;
      send(0, 0, IDLE_D, 8'hFF);
      reset = 1'b0;
      send(0, 1, T5, 8'hE0);
      send(0, 1, IDLE_D, 8'hFF);
      chk("rst frame_cnt", {48'd0, a_fcnt}, 64'd0);
      chk("rst err_cnt", {48'd0, a_ecnt}, 64'd0);
      chk("rst b counters", {60'd0, b_fcnt, b_ecnt}, 64'd0);

      // Instance B (MAX_BEATS=4): six-beat frame cancels on beat 4.
      exp_beat(1, 2'b01, 0, 4'd8, S0);                 send(1, 1, S0, 8'h01);
      exp_beat(1, 2'b00, 0, 4'd8, {8{8'h01}});         send(1, 1, {8{8'h01}}, 8'h00);
      exp_beat(1, 2'b00, 0, 4'd8, {8{8'h02}});         send(1, 1, {8{8'h02}}, 8'h00);
      exp_cancel(1);                                   send(1, 1, {8{8'h03}}, 8'h00);
      send(1, 1, {8{8'h04}}, 8'h00);
      send(1, 1, T0, 8'hFF);
      chk("b long err_cnt", {62'd0, b_ecnt}, 64'd1);
      chk("b long frame_cnt", {62'd0, b_fcnt}, 64'd0);

      // Exactly four beats with term on the last is accepted.
      exp_beat(1, 2'b01, 0, 4'd8, S0);                 send(1, 1, S0, 8'h01);
      exp_beat(1, 2'b00, 0, 4'd8, {8{8'h0A}});         send(1, 1, {8{8'h0A}}, 8'h00);
      exp_beat(1, 2'b00, 0, 4'd8, {8{8'h0B}});         send(1, 1, {8{8'h0B}}, 8'h00);
      exp_beat(1, 2'b00, 1, 4'd4, T4);                 send(1, 1, T4, 8'hF0);
      chk("b max frame_cnt", {62'd0, b_fcnt}, 64'd1);

      // Two-bit frame counter saturates at 3.
      for (int i = 2; i <= 4; i++) begin
         exp_beat(1, 2'b01, 0, 4'd8, S0);              send(1, 1, S0, 8'h01);
         exp_beat(1, 2'b00, 1, 4'd4, T4);              send(1, 1, T4, 8'hF0);
         chk($sformatf("b sat frame_cnt %0d", i), {62'd0, b_fcnt}, (i > 3) ? 64'd3 : 64'(i));
      end
      chk("b sat err_cnt", {62'd0, b_ecnt}, 64'd1);

      send(1, 0, IDLE_D, 8'hFF);
      send(0, 0, IDLE_D, 8'hFF);
      chk("qa drained", 64'(qa.size()), 64'd0);
      chk("qb drained", 64'(qb.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_xgmii_rx_adapter
`default_nettype wire
